row_shifter: RTL and testbench
==============================

ROW_SHIFTER -- requirements
Module: row_shifter

Interface
REQ-001 The block SHALL have parameter SCLK_HALF, default 2, meaning clk cycles per sclk half-period (legal range 1-15).
REQ-002 The block SHALL have parameter LATCH_CYCLES, default 30, meaning clk cycles latch is held high (300 ns at 100 MHz; legal range 1-63).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port run  input  1  level; while high, rows are loaded continuously.
REQ-006 The block SHALL have port rowData  input  24  pixel data for rowAddr, {R[7:0],G[7:0],B[7:0]}, valid one cycle after rowAddr changes (synchronous-read buffer).
REQ-007 The block SHALL have port rowAdvance  input  1  acknowledge pulse from the row selector; the loaded row has been displayed.
REQ-008 The block SHALL have port rowAddr  output  3  row currently being fetched/shifted.
REQ-009 The block SHALL have port sdOut  output  1  serial column data to the LED column driver.
REQ-010 The block SHALL have port sclk  output  1  shift clock; the driver samples sdOut on the sclk rising edge.
REQ-011 The block SHALL have port latch  output  1  column-driver latch strobe.
REQ-012 The block SHALL have port isFilled  output  1  the row is shifted and latched, awaiting rowAdvance.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL implement states IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, FILLED.
REQ-015 IDLE -> FETCH when run=1, else stay in IDLE; rowAddr unchanged.
REQ-016 FETCH SHALL last exactly 2 cycles; on the 2nd cycle a 24-bit shift register loads rowData, bit counter = 23, then -> SHIFT_LO.
REQ-017 SHIFT_LO: sclk=0, sdOut = shift register bit 23, held SCLK_HALF cycles, then -> SHIFT_HI.
REQ-018 SHIFT_HI: sclk=1, sdOut stable, held SCLK_HALF cycles; on exit the register shifts left 1; -> SHIFT_LO if bit counter > 0 (counter decrements), else -> LATCH.
REQ-019 Transmission SHALL be MSB first (R7 ... B0), exactly 24 sclk rising edges per row; shifting SHALL take 48*SCLK_HALF cycles.
REQ-020 LATCH: latch=1, sclk=0 for exactly LATCH_CYCLES cycles, then -> FILLED.
REQ-021 FILLED: isFilled=1, all other strobes low; stay until rowAdvance=1 is sampled.
REQ-022 On rowAdvance in FILLED, rowAddr SHALL increment modulo 8 (7 -> 0) in the same edge; next state FETCH if run=1, else IDLE; isFilled is low the following cycle.
REQ-023 rowAdvance SHALL be ignored in every state except FILLED.
REQ-024 Deasserting run mid-row SHALL NOT abort the row; the block completes through FILLED and stops in IDLE after rowAdvance.
REQ-025 rowData SHALL be sampled only on the 2nd FETCH cycle; changes at other times SHALL NOT affect sdOut.
REQ-026 latch and sclk SHALL never be high in the same cycle; sdOut SHALL not change while sclk=1.
REQ-027 Internal delay counters SHALL be wide enough for the parameter ranges with no overflow.

Reset
REQ-028 While reset=1 the block SHALL enter IDLE next edge with rowAddr=0, sdOut=0, sclk=0, latch=0, isFilled=0, busy=0, shift register and counters cleared.
REQ-029 Reset SHALL take priority over run and rowAdvance and SHALL abort any in-progress row (no latch pulse follows).

Verification
REQ-030 Reset, run=1, rowData=24'hA5_00_FF for row 0 -> 24 sclk edges with sampled bits 1010_0101_0000_0000_1111_1111, latch high 30 cycles, isFilled=1 at cycle 2+96+30 after FETCH entry.
REQ-031 Hold rowAdvance low 500 cycles in FILLED -> isFilled stays 1, no sclk/latch activity, rowAddr=0; pulse rowAdvance -> rowAddr=1, FETCH next cycle.
REQ-032 run=1 through 8 rowAdvance acks -> rowAddr sequence 0,1,...,7,0; exactly 8 latch pulses.
REQ-033 Drop run during SHIFT of row 3, pulse rowAdvance at FILLED -> rowAddr=4, state IDLE, busy=0, no further sclk.
REQ-034 Assert reset during bit 10 of SHIFT -> next cycle all outputs at reset values, no latch pulse; rowAdvance pulses while IDLE/SHIFT -> no effect on rowAddr.
REQ-035 SCLK_HALF=1, LATCH_CYCLES=1 -> row completes in 2+48+1 cycles to isFilled, sclk period 2 cycles, latch width 1 cycle.

Source files
------------

// File: rtl/row_shifter.sv
// row_shifter: fetches one 24-bit RGB row from a synchronous-read buffer.
// It shifts the row MSB first to an LED column driver on sdOut/sclk.
// It then pulses latch and waits in FILLED until the row selector
// acknowledges with rowAdvance. The acknowledge moves on to the next row.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   run        level; while high, rows are loaded back to back
//   rowData    {R,G,B} for rowAddr, valid one cycle after rowAddr changes
//   rowAdvance row-selector acknowledge, honoured only in FILLED
//   rowAddr    row being fetched/shifted
//   sdOut      serial column data, stable while sclk is high
//   sclk       shift clock, driver samples sdOut on its rising edge
//   latch      column-driver latch strobe
//   isFilled   row shifted and latched, awaiting rowAdvance
//   busy       high in every state except IDLE
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | stopped, waiting for run
// FETCH    | 2 cycles: address settles, then rowData is captured
// SHIFT_LO | sclk low, sdOut presents the next bit
// SHIFT_HI | sclk high, driver samples sdOut
// LATCH    | latch strobe held high for LATCH_CYCLES
// FILLED   | row displayed-ready, waiting for rowAdvance
module row_shifter #(
  parameter int SCLK_HALF    = 2,
  parameter int LATCH_CYCLES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [23:0] rowData,
  input  logic        rowAdvance,
  output logic [2:0]  rowAddr,
  output logic        sdOut,
  output logic        sclk,
  output logic        latch,
  output logic        isFilled,
  output logic        busy
);

  // The delay counter holds (duration - 1), so it must reach MAX_DLY - 1.
  localparam int MAX_DLY = (SCLK_HALF > LATCH_CYCLES) ? SCLK_HALF : LATCH_CYCLES;
  localparam int DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam logic [DLY_W-1:0] SCLK_RELOAD  = DLY_W'(SCLK_HALF - 1);
  localparam logic [DLY_W-1:0] LATCH_RELOAD = DLY_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_FILLED
  } state_t;

  state_t           state_q, state_d;
  logic             fetch2_q, fetch2_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [2:0]       row_q, row_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fetch2_q <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      dly_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      fetch2_q <= fetch2_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      dly_q    <= dly_d;
      row_q    <= row_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fetch2_d = fetch2_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    dly_d    = dly_q;
    row_d    = row_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_FETCH;
          fetch2_d = 1'b0;
        end
      end

      // First cycle lets the buffer's registered read catch up with rowAddr.
      S_FETCH: begin
        if (fetch2_q) begin
          shreg_d  = rowData;
          bitcnt_d = 5'd23;
          dly_d    = SCLK_RELOAD;
          fetch2_d = 1'b0;
          state_d  = S_SHIFT_LO;
        end else begin
          fetch2_d = 1'b1;
        end
      end

      S_SHIFT_LO: begin
        if (dly_q == '0) begin
          dly_d   = SCLK_RELOAD;
          state_d = S_SHIFT_HI;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end

      // Shift only when leaving the high phase so sdOut cannot move under sclk=1.
      S_SHIFT_HI: begin
        if (dly_q == '0) begin
          shreg_d = {shreg_q[22:0], 1'b0};
          if (bitcnt_q != 5'd0) begin
            bitcnt_d = bitcnt_q - 5'd1;
            dly_d    = SCLK_RELOAD;
            state_d  = S_SHIFT_LO;
          end else begin
            dly_d   = LATCH_RELOAD;
            state_d = S_LATCH;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end

      S_LATCH: begin
        if (dly_q == '0) begin
          state_d = S_FILLED;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end

      S_FILLED: begin
        if (rowAdvance) begin
          row_d    = row_q + 3'd1;
          fetch2_d = 1'b0;
          state_d  = run ? S_FETCH : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // After 24 shifts the register is all zeros, so sdOut idles low.
  assign rowAddr  = row_q;
  assign sdOut    = shreg_q[23];
  assign sclk     = (state_q == S_SHIFT_HI);
  assign latch    = (state_q == S_LATCH);
  assign isFilled = (state_q == S_FILLED);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_row_shifter.sv
// Bench for row_shifter. A default instance and a SCLK_HALF=1/LATCH_CYCLES=1
// instance share clk/reset/run/rowAdvance. Each instance has its own row buffer
// fed from one random memory. The sel input picks which instance is observed.
// Expected values come from the row memory, from the closed-form timing
// 2 + 48*SCLK_HALF + LATCH_CYCLES, and from a modulo-8 row counter.
module tb_row_shifter;

  logic        clk = 1'b0;
  logic        reset, run, rowAdvance, sel;
  logic [23:0] m_rowData, f_rowData;
  logic [2:0]  m_rowAddr, f_rowAddr;
  logic        m_sdOut, m_sclk, m_latch, m_isFilled, m_busy;
  logic        f_sdOut, f_sclk, f_latch, f_isFilled, f_busy;

  logic [2:0]  o_rowAddr;
  logic        o_sdOut, o_sclk, o_latch, o_isFilled, o_busy;

  logic [23:0] mem [8];
  logic [2:0]  exp_row;
  int          n_chk = 0;
  int          n_pass = 0;
  int          latch_pulses = 0;

  always #5 clk = ~clk;

  row_shifter u_dut (
    .clk(clk), .reset(reset), .run(run), .rowData(m_rowData),
    .rowAdvance(rowAdvance), .rowAddr(m_rowAddr), .sdOut(m_sdOut),
    .sclk(m_sclk), .latch(m_latch), .isFilled(m_isFilled), .busy(m_busy)
  );

  row_shifter #(.SCLK_HALF(1), .LATCH_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .run(run), .rowData(f_rowData),
    .rowAdvance(rowAdvance), .rowAddr(f_rowAddr), .sdOut(f_sdOut),
    .sclk(f_sclk), .latch(f_latch), .isFilled(f_isFilled), .busy(f_busy)
  );

  // Synchronous-read row buffers.
  always @(posedge clk) begin
    m_rowData <= mem[m_rowAddr];
    f_rowData <= mem[f_rowAddr];
  end

  assign o_rowAddr  = sel ? f_rowAddr  : m_rowAddr;
  assign o_sdOut    = sel ? f_sdOut    : m_sdOut;
  assign o_sclk     = sel ? f_sclk     : m_sclk;
  assign o_latch    = sel ? f_latch    : m_latch;
  assign o_isFilled = sel ? f_isFilled : m_isFilled;
  assign o_busy     = sel ? f_busy     : m_busy;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first FETCH cycle. Runs until FILLED or until the cycle budget expires.
  task automatic do_row(input bit drop_run);
    int n, sh, lc, edges, lat_w, prev_rise, per_err, stab_err, overlap, addr_err;
    logic [23:0] exp_bits, got_bits;
    logic [2:0]  row0;
    logic        prev_sclk, prev_latch, held_sd;
    sh = sel ? 1 : 2;
    lc = sel ? 1 : 30;
    row0 = exp_row;
    exp_bits = mem[exp_row];
    got_bits = '0;
    n = 0; edges = 0; lat_w = 0; prev_rise = -1;
    per_err = 0; stab_err = 0; overlap = 0; addr_err = 0;
    prev_sclk = 1'b0; prev_latch = 1'b0; held_sd = 1'b0;
    chk("fetch_busy", int'(o_busy), 1);
    chk("fetch_row", int'(o_rowAddr), int'(exp_row));
    while (!o_isFilled && n < 2 + 48 * sh + lc + 20) begin
      if (o_sclk && !prev_sclk) begin
        got_bits = {got_bits[22:0], o_sdOut};
        held_sd = o_sdOut;
        edges++;
        if (prev_rise >= 0 && n - prev_rise != 2 * sh) per_err++;
        prev_rise = n;
      end
      if (o_sclk && o_sdOut != held_sd) stab_err++;
      if (o_sclk && o_latch) overlap++;
      if (o_latch) lat_w++;
      if (o_latch && !prev_latch) latch_pulses++;
      if (o_rowAddr != row0) addr_err++;
      if (n == 6) mem[row0] = 24'($urandom);
      if (n == 20 && drop_run) run = 1'b0;
      rowAdvance = ($urandom_range(0, 3) == 0);
      prev_sclk = o_sclk;
      prev_latch = o_latch;
      step();
      n++;
    end
    rowAdvance = 1'b0;
    chk("filled_cycle", n, 2 + 48 * sh + lc);
    chk("sclk_edges", edges, 24);
    chk("row_bits", int'(got_bits), int'(exp_bits));
    chk("latch_width", lat_w, lc);
    chk("sclk_period", per_err, 0);
    chk("sd_stable_hi", stab_err, 0);
    chk("latch_sclk_overlap", overlap, 0);
    chk("row_hold_adv_ignored", addr_err, 0);
    chk("filled_busy", int'(o_busy), 1);
  endtask

  task automatic ack(input int wait_cyc);
    repeat (wait_cyc) step();
    chk("pre_ack_filled", int'(o_isFilled), 1);
    rowAdvance = 1'b1;
    step();
    rowAdvance = 1'b0;
    exp_row = exp_row + 3'd1;
    chk("ack_row", int'(o_rowAddr), int'(exp_row));
    chk("ack_filled_low", int'(o_isFilled), 0);
    chk("ack_busy", int'(o_busy), int'(run));
  endtask

  initial begin
    int viol, edges, n;
    logic prev;
    reset = 1'b1; run = 1'b0; rowAdvance = 1'b0; sel = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    mem[0] = 24'hA500FF;
    exp_row = '0;

    repeat (3) step();
    chk("rst_rowAddr", int'(o_rowAddr), 0);
    chk("rst_sdOut", int'(o_sdOut), 0);
    chk("rst_sclk", int'(o_sclk), 0);
    chk("rst_latch", int'(o_latch), 0);
    chk("rst_isFilled", int'(o_isFilled), 0);
    chk("rst_busy", int'(o_busy), 0);

    reset = 1'b0;
    step();
    chk("idle_no_run", int'(o_busy), 0);

    run = 1'b1;
    step();
    do_row(1'b0);

    viol = 0;
    repeat (500) begin
      if (!o_isFilled || o_sclk || o_latch || o_rowAddr != 3'd0) viol++;
      step();
    end
    chk("filled_hold", viol, 0);
    ack(0);

    for (int r = 1; r < 8; r++) begin
      do_row(1'b0);
      ack($urandom_range(0, 5));
    end
    chk("latch_pulses_8", latch_pulses, 8);

    for (int r = 0; r < 3; r++) begin
      do_row(1'b0);
      ack($urandom_range(0, 5));
    end
    do_row(1'b1);
    ack(2);
    chk("stop_row", int'(o_rowAddr), 4);
    chk("stop_busy", int'(o_busy), 0);

    viol = 0;
    for (int i = 0; i < 30; i++) begin
      rowAdvance = (i % 5 == 0);
      if (o_sclk || o_busy || o_rowAddr != 3'd4) viol++;
      step();
    end
    rowAdvance = 1'b0;
    chk("idle_quiet", viol, 0);

    run = 1'b1;
    step();
    edges = 0; n = 0; prev = 1'b0;
    while (edges < 11 && n < 400) begin
      if (o_sclk && !prev) edges++;
      prev = o_sclk;
      if (edges < 11) begin
        step();
        n++;
      end
    end
    chk("rst_mid_found", edges, 11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run = 1'b0;
    exp_row = '0;
    chk("abort_rowAddr", int'(o_rowAddr), 0);
    chk("abort_sdOut", int'(o_sdOut), 0);
    chk("abort_sclk", int'(o_sclk), 0);
    chk("abort_latch", int'(o_latch), 0);
    chk("abort_isFilled", int'(o_isFilled), 0);
    chk("abort_busy", int'(o_busy), 0);

    viol = 0;
    repeat (100) begin
      rowAdvance = ($urandom_range(0, 2) == 0);
      if (o_latch || o_busy || o_rowAddr != 3'd0) viol++;
      step();
    end
    rowAdvance = 1'b0;
    chk("post_abort_quiet", viol, 0);

    run = 1'b1;
    step();
    do_row(1'b0);

    reset = 1'b1; run = 1'b0; rowAdvance = 1'b0;
    repeat (2) step();
    sel = 1'b1;
    reset = 1'b0;
    exp_row = '0;
    run = 1'b1;
    step();
    do_row(1'b0);
    ack(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
